// File: rtl/pc_unit_if.sv
// pc_unit_if
//   Bus between the multicycle control/datapath and the program-counter unit.
//   master : control unit / datapath side (drives control, ALU data, IR field,
//            exception request; observes PC state)
//   slave  : pc_unit side
//   Signals:
//     PCWrite, PCWriteCond, BranchNe, PCSource[1:0]  control from main FSM
//     ALUResult[31:0], ALUOut[31:0], Zero             ALU results
//     Instr26[25:0]                                   IR[25:0] for jumps
//     ExcReq, ExcCause[1:0]                           exception request
//     PC[31:0], EPC[31:0], Cause[1:0]                 PC unit state
//     ExcBusy, AlignErr                               status
interface pc_unit_if;
  logic        PCWrite;
  logic        PCWriteCond;
  logic        BranchNe;
  logic [1:0]  PCSource;
  logic [31:0] ALUResult;
  logic [31:0] ALUOut;
  logic        Zero;
  logic [25:0] Instr26;
  logic        ExcReq;
  logic [1:0]  ExcCause;
  logic [31:0] PC;
  logic [31:0] EPC;
  logic [1:0]  Cause;
  logic        ExcBusy;
  logic        AlignErr;

  modport master (
    output PCWrite, PCWriteCond, BranchNe, PCSource,
    output ALUResult, ALUOut, Zero, Instr26,
    output ExcReq, ExcCause,
    input  PC, EPC, Cause, ExcBusy, AlignErr
  );

  modport slave (
    input  PCWrite, PCWriteCond, BranchNe, PCSource,
    input  ALUResult, ALUOut, Zero, Instr26,
    input  ExcReq, ExcCause,
    output PC, EPC, Cause, ExcBusy, AlignErr
  );
endinterface

// File: rtl/pc_unit.sv
// pc_unit
//   Program-counter unit for the multicycle MIPS core. Holds the PC, resolves
//   BEQ/BNE, forms jump targets and runs a two-cycle exception sequencer that
//   saves EPC/Cause and redirects the PC to a per-cause handler vector.
//   Ports:
//     Clk    in   rising-edge clock
//     Reset  in   asynchronous, active-high reset
//     bus    pc_unit_if.slave (control/data in, PC/EPC/Cause/status out)
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   IDLE      | normal PC loads; an ExcReq here saves EPC/Cause
//   EXC_LOAD  | second exception cycle: PC <= vector of latched Cause
module pc_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] VEC_OPCODE = 32'h0000_00FC,
  parameter logic [31:0] VEC_OVF    = 32'h0000_00F8,
  parameter logic [31:0] VEC_DIV0   = 32'h0000_00F4
) (
  input logic        Clk,
  input logic        Reset,
  pc_unit_if.slave   bus
);

  typedef enum logic {
    IDLE     = 1'b0,
    EXC_LOAD = 1'b1
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc_q, pc_nxt;
  logic [31:0] epc_q, epc_nxt;
  logic [1:0]  cause_q, cause_nxt;
  logic        align_q, align_nxt;

  logic        take;
  logic        load;
  logic [31:0] jump_tgt;
  logic [31:0] next_pc;
  logic [31:0] vector;

  // PC already holds PC+4 at this point, so the jump region comes from it.
  assign jump_tgt = {pc_q[31:28], bus.Instr26, 2'b00};
  assign take     = bus.PCWriteCond & (bus.Zero ^ bus.BranchNe);
  assign load     = bus.PCWrite | take;

  always_comb begin
    next_pc = bus.ALUResult;
    unique case (bus.PCSource)
      2'b00: next_pc = bus.ALUResult;
      2'b01: next_pc = bus.ALUOut;
      2'b10: next_pc = jump_tgt;
      2'b11: next_pc = epc_q;
    endcase
  end

  // Cause 3 is unassigned and shares the invalid-opcode handler.
  always_comb begin
    vector = VEC_OPCODE;
    unique case (cause_q)
      2'd1:    vector = VEC_OVF;
      2'd2:    vector = VEC_DIV0;
      default: vector = VEC_OPCODE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      pc_q    <= RESET_PC;
      epc_q   <= 32'h0;
      cause_q <= 2'd0;
      align_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      pc_q    <= pc_nxt;
      epc_q   <= epc_nxt;
      cause_q <= cause_nxt;
      align_q <= align_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_q;
    epc_nxt   = epc_q;
    cause_nxt = cause_q;
    align_nxt = 1'b0;
    unique case (state)
      IDLE: begin
        // An exception wins over any PC load requested in the same cycle.
        if (bus.ExcReq) begin
          epc_nxt   = pc_q - 32'd4;
          cause_nxt = bus.ExcCause;
          state_nxt = EXC_LOAD;
        end else if (load) begin
          if (next_pc[1:0] == 2'b00) begin
            pc_nxt = next_pc;
          end else begin
            align_nxt = 1'b1;
          end
        end
      end
      EXC_LOAD: begin
        pc_nxt    = vector;
        state_nxt = IDLE;
      end
    endcase
  end

  assign bus.PC       = pc_q;
  assign bus.EPC      = epc_q;
  assign bus.Cause    = cause_q;
  assign bus.ExcBusy  = (state == EXC_LOAD);
  assign bus.AlignErr = align_q;

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit
//   Directed checks of the documented scenarios followed by a randomized run,
//   all compared against a behavioural model of the PC unit kept here.
module tb_pc_unit;
  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] VEC_OPCODE = 32'h0000_00FC;
  localparam logic [31:0] VEC_OVF    = 32'h0000_00F8;
  localparam logic [31:0] VEC_DIV0   = 32'h0000_00F4;

  logic Clk;
  logic Reset;
  pc_unit_if bus ();

  pc_unit #(
    .RESET_PC  (RESET_PC),
    .VEC_OPCODE(VEC_OPCODE),
    .VEC_OVF   (VEC_OVF),
    .VEC_DIV0  (VEC_DIV0)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Behavioural model: architectural view of the unit.
  logic [31:0] m_pc, m_epc;
  logic [1:0]  m_cause;
  logic        m_busy, m_align;
  logic [31:0] vec_tab [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RESET_PC; m_epc = 32'h0; m_cause = 2'd0; m_busy = 1'b0; m_align = 1'b0;
  endtask

  // What one rising edge does, given the inputs currently on the bus.
  task automatic model_edge();
    logic [31:0] tgt;
    logic        ld;
    if (m_busy) begin
      m_pc    = vec_tab[m_cause];
      m_busy  = 1'b0;
      m_align = 1'b0;
    end else if (bus.ExcReq) begin
      m_epc   = m_pc - 32'd4;
      m_cause = bus.ExcCause;
      m_busy  = 1'b1;
      m_align = 1'b0;
    end else begin
      ld = bus.PCWrite || (bus.PCWriteCond && (bus.Zero != bus.BranchNe));
      case (bus.PCSource)
        2'd0:    tgt = bus.ALUResult;
        2'd1:    tgt = bus.ALUOut;
        2'd2:    tgt = (m_pc & 32'hF000_0000) + ({6'd0, bus.Instr26} * 4);
        default: tgt = m_epc;
      endcase
      m_align = 1'b0;
      if (ld) begin
        if (tgt % 4 == 0) m_pc = tgt;
        else m_align = 1'b1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".PC"},       bus.PC,               m_pc);
    chk({tag, ".EPC"},      bus.EPC,              m_epc);
    chk({tag, ".Cause"},    {30'd0, bus.Cause},    {30'd0, m_cause});
    chk({tag, ".ExcBusy"},  {31'd0, bus.ExcBusy},  {31'd0, m_busy});
    chk({tag, ".AlignErr"}, {31'd0, bus.AlignErr}, {31'd0, m_align});
  endtask

  task automatic tick();
    @(posedge Clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    bus.PCWrite = 0; bus.PCWriteCond = 0; bus.BranchNe = 0; bus.PCSource = 2'd0;
    bus.ALUResult = 0; bus.ALUOut = 0; bus.Zero = 0; bus.Instr26 = 0;
    bus.ExcReq = 0; bus.ExcCause = 2'd0;
  endtask

  task automatic load_pc(input logic [31:0] v);
    idle_inputs();
    bus.PCWrite = 1; bus.PCSource = 2'd0; bus.ALUResult = v;
    tick();
    idle_inputs();
  endtask

  initial begin
    vec_tab[0] = VEC_OPCODE; vec_tab[1] = VEC_OVF;
    vec_tab[2] = VEC_DIV0;   vec_tab[3] = VEC_OPCODE;

    // Reset
    idle_inputs();
    Reset = 1'b1;
    model_reset();
    #12;
    check_all("reset");
    @(negedge Clk);
    Reset = 1'b0;

    // Sequential PC+4 load
    bus.PCWrite = 1; bus.ALUResult = 32'h4;
    tick();
    chk("inc.PC", bus.PC, 32'h4);
    check_all("inc");

    // BEQ taken, BEQ not taken, BNE taken
    idle_inputs();
    bus.PCWriteCond = 1; bus.BranchNe = 0; bus.Zero = 1; bus.PCSource = 2'd1; bus.ALUOut = 32'h40;
    tick();
    chk("beq_taken.PC", bus.PC, 32'h40);
    bus.Zero = 0; bus.ALUOut = 32'h80;
    tick();
    chk("beq_not.PC", bus.PC, 32'h40);
    bus.BranchNe = 1;
    tick();
    chk("bne_taken.PC", bus.PC, 32'h80);
    check_all("branch");

    // Jump
    load_pc(32'h1000_0008);
    bus.PCWrite = 1; bus.PCSource = 2'd2; bus.Instr26 = 26'h0000010;
    tick();
    chk("jump.PC", bus.PC, 32'h1000_0040);
    check_all("jump");

    // Overflow exception with a competing PCWrite
    load_pc(32'h24);
    bus.ExcReq = 1; bus.ExcCause = 2'd1; bus.PCWrite = 1; bus.ALUResult = 32'h100;
    tick();
    chk("ovf1.EPC", bus.EPC, 32'h20);
    chk("ovf1.PC", bus.PC, 32'h24);
    chk("ovf1.Busy", {31'd0, bus.ExcBusy}, 32'd1);
    bus.ExcReq = 0;
    tick();
    chk("ovf2.PC", bus.PC, 32'hF8);
    chk("ovf2.Busy", {31'd0, bus.ExcBusy}, 32'd0);
    idle_inputs();
    bus.PCWrite = 1; bus.PCSource = 2'd3;
    tick();
    chk("eret.PC", bus.PC, 32'h20);
    check_all("eret");

    // Misaligned load rejected, AlignErr for one cycle only
    idle_inputs();
    bus.PCWrite = 1; bus.ALUResult = 32'h42;
    tick();
    chk("mis.PC", bus.PC, 32'h20);
    chk("mis.Align", {31'd0, bus.AlignErr}, 32'd1);
    idle_inputs();
    tick();
    chk("mis.AlignOff", {31'd0, bus.AlignErr}, 32'd0);

    // EPC wrap from PC=0, divide-by-zero vector, then cause 3 vector
    load_pc(32'h0);
    bus.ExcReq = 1; bus.ExcCause = 2'd2;
    tick();
    chk("wrap.EPC", bus.EPC, 32'hFFFF_FFFC);
    tick();
    chk("div0.PC", bus.PC, 32'hF4);
    bus.ExcCause = 2'd3;
    tick();
    tick();
    chk("cause3.PC", bus.PC, 32'hFC);
    check_all("cause3");
    idle_inputs();

    // Reset during EXC_LOAD aborts the sequence immediately
    load_pc(32'h300);
    bus.ExcReq = 1; bus.ExcCause = 2'd1;
    tick();
    idle_inputs();
    #2;
    Reset = 1'b1;
    model_reset();
    #1;
    chk("rst_abort.PC", bus.PC, RESET_PC);
    chk("rst_abort.Busy", {31'd0, bus.ExcBusy}, 32'd0);
    chk("rst_abort.EPC", bus.EPC, 32'h0);
    @(posedge Clk);
    #1;
    check_all("rst_hold");
    @(negedge Clk);
    Reset = 1'b0;

    // Randomized run against the model
    for (int i = 0; i < 600; i++) begin
      bus.PCWrite     = ($urandom_range(0, 3) == 0);
      bus.PCWriteCond = ($urandom_range(0, 2) == 0);
      bus.BranchNe    = 1'($urandom);
      bus.Zero        = 1'($urandom);
      bus.PCSource    = 2'($urandom);
      bus.ALUResult   = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      bus.ALUOut      = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      bus.Instr26     = 26'($urandom);
      bus.ExcReq      = ($urandom_range(0, 9) == 0);
      bus.ExcCause    = 2'($urandom);
      tick();
      check_all("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule
